// File: rtl/cpu_prefetch.sv
// Instruction prefetch stage for the 65C02-compatible execute core.
// Fetches 32-bit little-endian words from the word-addressed RAM into an
// 8-byte circular queue. It decodes the instruction length of the opcode at
// the queue head and presents complete instructions over valid/ready.
// A redirect flushes the queue. A read already in flight is drained and its
// data dropped.
module cpu_prefetch #(
    parameter logic [15:0] RESET_PC = 16'hFFFC,
    parameter int          QDEPTH   = 8
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic        o_mem_req,
    output logic [13:0] o_mem_addr,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_data,
    input  logic        i_redirect,
    input  logic [15:0] i_redirect_pc,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [7:0]  o_opcode,
    output logic [15:0] o_operand,
    output logic [1:0]  o_length,
    output logic [15:0] o_pc
);

    localparam logic [3:0] QDEPTH_C = 4'(QDEPTH);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_DISCARD = 2'd2
    } state_t;

    // 65C02 instruction length from the opcode byte.
    function automatic logic [1:0] insn_length(input logic [7:0] op);
        logic [1:0] len;
        case (op[3:0])
            4'h0: begin
                if (op == 8'h20) begin
                    len = 2'd3;
                end else if ((op == 8'h40) || (op == 8'h60)) begin
                    len = 2'd1;
                end else begin
                    len = 2'd2;
                end
            end
            4'h1, 4'h2, 4'h4, 4'h5, 4'h6, 4'h7: len = 2'd2;
            4'h3, 4'h8, 4'hA, 4'hB:             len = 2'd1;
            4'h9:                               len = op[4] ? 2'd3 : 2'd2;
            4'hC, 4'hD, 4'hE, 4'hF:             len = 2'd3;
            default:                            len = 2'd1;
        endcase
        return len;
    endfunction

    state_t      state_q, state_d;
    logic [15:0] fetch_pc_q, fetch_pc_d;
    logic [15:0] head_pc_q, head_pc_d;
    logic [3:0]  count_q, count_d;
    logic [2:0]  head_q, head_d;
    logic [2:0]  tail_q, tail_d;
    logic [13:0] mem_addr_q, mem_addr_d;
    logic [7:0]  queue_q [QDEPTH];
    logic [7:0]  queue_d [QDEPTH];

    logic [7:0]  head_byte_s;
    logic [7:0]  byte1_s;
    logic [7:0]  byte2_s;
    logic [1:0]  head_len_s;
    logic        valid_s;
    logic        consume_s;
    logic        ack_write_s;
    logic [2:0]  wr_count_s;
    logic        room_s;

    // Head-of-queue decode and the handshake/write qualifiers.
    always_comb begin
        head_byte_s = queue_q[head_q];
        byte1_s     = queue_q[head_q + 3'd1];
        byte2_s     = queue_q[head_q + 3'd2];
        head_len_s  = insn_length(head_byte_s);
        valid_s     = (count_q != 4'd0) && (count_q >= {2'b00, head_len_s});
        consume_s   = valid_s && i_ready && !i_redirect;
        ack_write_s = (state_q == ST_WAIT) && i_mem_ack && !i_redirect;
        // An unaligned fetch PC only keeps the upper bytes of its word.
        wr_count_s  = 3'd4 - {1'b0, fetch_pc_q[1:0]};
        room_s      = ((QDEPTH_C - count_q) >= 4'd4);
    end

    // Fetch FSM state register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Fetch FSM next state. An ack always ends the outstanding read. A
    // redirect before the ack parks in DISCARD so that the ack is drained.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (!i_redirect && room_s) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (i_mem_ack) begin
                    state_d = ST_IDLE;
                end else if (i_redirect) begin
                    state_d = ST_DISCARD;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_DISCARD: begin
                if (i_mem_ack) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DISCARD;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Fetch FSM and queue outputs. These are derived from registered state only.
    always_comb begin
        o_mem_req  = (state_q != ST_IDLE);
        o_mem_addr = mem_addr_q;
        o_valid    = valid_s;
        o_pc       = head_pc_q;
        if (valid_s) begin
            o_opcode  = head_byte_s;
            o_length  = head_len_s;
            o_operand = {((head_len_s == 2'd3) ? byte2_s : 8'h00),
                         ((head_len_s != 2'd1) ? byte1_s : 8'h00)};
        end else begin
            o_opcode  = 8'h00;
            o_length  = 2'd1;
            o_operand = 16'h0000;
        end
    end

    // Pointer, counter and PC next state. A redirect overrides both the
    // consume and the queue write.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        head_pc_d  = head_pc_q;
        count_d    = count_q;
        head_d     = head_q;
        tail_d     = tail_q;
        mem_addr_d = mem_addr_q;
        if (i_redirect) begin
            fetch_pc_d = i_redirect_pc;
            head_pc_d  = i_redirect_pc;
            count_d    = 4'd0;
            head_d     = 3'd0;
            tail_d     = 3'd0;
        end else begin
            if (ack_write_s) begin
                fetch_pc_d = {fetch_pc_q[15:2] + 14'd1, 2'b00};
                tail_d     = tail_q + wr_count_s;
            end else begin
                fetch_pc_d = fetch_pc_q;
                tail_d     = tail_q;
            end
            if (consume_s) begin
                head_d    = head_q + {1'b0, head_len_s};
                head_pc_d = head_pc_q + {14'd0, head_len_s};
            end else begin
                head_d    = head_q;
                head_pc_d = head_pc_q;
            end
            count_d = count_q
                    + {1'b0, (ack_write_s ? wr_count_s : 3'd0)}
                    - {2'b00, (consume_s ? head_len_s : 2'd0)};
        end
        // Latch the word address at issue so that it holds until the ack,
        // even if a redirect moves the fetch PC meanwhile.
        if ((state_q == ST_IDLE) && (state_d == ST_WAIT)) begin
            mem_addr_d = fetch_pc_q[15:2];
        end else begin
            mem_addr_d = mem_addr_q;
        end
    end

    // Queue byte writes. Bytes from the fetch offset up to byte 3 land at
    // the tail in ascending order.
    always_comb begin
        queue_d = queue_q;
        if (ack_write_s) begin
            for (int k = 0; k < 4; k++) begin
                if (2'(k) >= fetch_pc_q[1:0]) begin
                    queue_d[tail_q + 3'(k) - {1'b0, fetch_pc_q[1:0]}] = i_mem_data[8*k +: 8];
                end else begin
                    queue_d[tail_q] = queue_d[tail_q];
                end
            end
        end else begin
            queue_d = queue_q;
        end
    end

    // Pointer, counter and PC registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            fetch_pc_q <= RESET_PC;
            head_pc_q  <= RESET_PC;
            count_q    <= 4'd0;
            head_q     <= 3'd0;
            tail_q     <= 3'd0;
            mem_addr_q <= RESET_PC[15:2];
        end else begin
            fetch_pc_q <= fetch_pc_d;
            head_pc_q  <= head_pc_d;
            count_q    <= count_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    // Queue storage. It is cleared on reset so that the head decode never sees X.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < QDEPTH; i++) begin
                queue_q[i] <= 8'h00;
            end
        end else begin
            for (int i = 0; i < QDEPTH; i++) begin
                queue_q[i] <= queue_d[i];
            end
        end
    end

endmodule

// File: tb/tb_cpu_prefetch.sv
// Bench for cpu_prefetch. A behavioural model walks the RAM image in program
// order from each reset or redirect PC. It queues the expected instructions,
// and a monitor pops and compares them on every accepted handshake.
module tb_cpu_prefetch;

    logic        i_clk;
    logic        i_rst;
    logic        o_mem_req;
    logic [13:0] o_mem_addr;
    logic        i_mem_ack;
    logic [31:0] i_mem_data;
    logic        i_redirect;
    logic [15:0] i_redirect_pc;
    logic        o_valid;
    logic        i_ready;
    logic [7:0]  o_opcode;
    logic [15:0] o_operand;
    logic [1:0]  o_length;
    logic [15:0] o_pc;

    cpu_prefetch #(.RESET_PC(16'h0000), .QDEPTH(8)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .o_mem_req(o_mem_req), .o_mem_addr(o_mem_addr),
        .i_mem_ack(i_mem_ack), .i_mem_data(i_mem_data),
        .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc),
        .o_valid(o_valid), .i_ready(i_ready),
        .o_opcode(o_opcode), .o_operand(o_operand),
        .o_length(o_length), .o_pc(o_pc)
    );

    logic [31:0] ram [16384];
    int          n_cmp = 0;
    int          n_fail = 0;
    logic [41:0] exp_q [$];
    logic [13:0] addr_log [$];
    logic [15:0] pred_pc;
    logic        prev_redir;
    int          redir_idx = 0;
    int          new_acks = 0;
    int          lat_cfg = -1;

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Instruction length for the 65C02, taken from the opcode-table rules.
    function automatic int ref_len(input logic [7:0] op);
        int lo;
        int hi;
        lo = int'(op) % 16;
        hi = int'(op) / 16;
        if (lo == 3 || lo == 8 || lo == 10 || lo == 11) return 1;
        if (lo >= 12) return 3;
        if (lo == 9) return (hi % 2 == 1) ? 3 : 2;
        if (lo == 0) begin
            if (op == 8'h20) return 3;
            if (op == 8'h40 || op == 8'h60) return 1;
            return 2;
        end
        return 2;
    endfunction

    function automatic logic [7:0] mem_byte(input logic [15:0] a);
        logic [31:0] w;
        w = ram[a[15:2]];
        return w[8*a[1:0] +: 8];
    endfunction

    task automatic push_pred();
        logic [7:0] op;
        logic [7:0] b1;
        logic [7:0] b2;
        int len;
        op  = mem_byte(pred_pc);
        len = ref_len(op);
        b1  = (len >= 2) ? mem_byte(pred_pc + 16'd1) : 8'h00;
        b2  = (len == 3) ? mem_byte(pred_pc + 16'd2) : 8'h00;
        exp_q.push_back({op, b2, b1, 2'(len), pred_pc});
        pred_pc = pred_pc + 16'(len);
    endtask

    // Monitor: track flushes, compare each accepted instruction, refill predictions.
    always @(negedge i_clk) begin
        logic [41:0] e;
        if (i_rst) begin
            exp_q.delete();
            pred_pc    = 16'h0000;
            prev_redir = 1'b0;
        end else begin
            if (prev_redir) chk("valid_after_redirect", 64'(o_valid), 64'd0);
            if (i_redirect) begin
                exp_q.delete();
                pred_pc = i_redirect_pc;
            end else if (o_valid && i_ready) begin
                if (exp_q.size() == 0) begin
                    chk("scoreboard_empty", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("instr", 64'({o_opcode, o_operand, o_length, o_pc}), 64'(e));
                end
            end
            prev_redir = i_redirect;
        end
        while (exp_q.size() < 16) push_pred();
    end

    // RAM responder: a random or fixed latency, with an address stability check.
    initial begin
        bit busy;
        int lat;
        int cur_idx;
        logic [13:0] cap_addr;
        busy = 1'b0; lat = 0; cur_idx = 0; cap_addr = 14'd0;
        i_mem_ack = 1'b0; i_mem_data = 32'd0;
        forever begin
            @(posedge i_clk); #1;
            i_mem_ack = 1'b0;
            if (i_rst) begin
                busy = 1'b0;
            end else if (o_mem_req) begin
                if (!busy) begin
                    busy     = 1'b1;
                    cap_addr = o_mem_addr;
                    cur_idx  = addr_log.size();
                    addr_log.push_back(o_mem_addr);
                    lat = (lat_cfg < 0) ? int'($urandom_range(0, 3)) : lat_cfg;
                end else begin
                    chk("addr_stable", 64'(o_mem_addr), 64'(cap_addr));
                end
                if (lat == 0) begin
                    i_mem_ack  = 1'b1;
                    i_mem_data = ram[cap_addr];
                    busy       = 1'b0;
                    if (cur_idx >= redir_idx) new_acks++;
                end else begin
                    lat--;
                end
            end
        end
    end

    task automatic do_redirect(input logic [15:0] pc);
        @(posedge i_clk); #1;
        i_redirect    = 1'b1;
        i_redirect_pc = pc;
        @(negedge i_clk);
        redir_idx = addr_log.size();
        new_acks  = 0;
        @(posedge i_clk); #1;
        i_redirect = 1'b0;
    endtask

    // Wait for the first o_valid after a redirect and check how many new-stream words it took.
    task automatic wait_valid(input string name, input int exp_acks);
        int cyc;
        cyc = 0;
        @(negedge i_clk);
        while (!o_valid && cyc < 60) begin
            @(negedge i_clk);
            cyc++;
        end
        chk({name, "_valid_seen"}, 64'(o_valid), 64'd1);
        chk({name, "_acks"}, 64'(new_acks), 64'(exp_acks));
    endtask

    initial begin
        int cyc;
        i_rst = 1'b1; i_ready = 1'b0; i_redirect = 1'b0; i_redirect_pc = 16'h0000;
        for (int i = 0; i < 16384; i++) ram[i] = $urandom;
        ram[14'h0000] = 32'h85A920EA;
        ram[14'h0080] = 32'hA1B2C3D4;
        ram[14'h0081] = 32'hEAEAEA7F;
        ram[14'h0140] = 32'h4C000000;
        ram[14'h0141] = 32'hEAEA3412;
        ram[14'h0040] = 32'hDEADBEEF;
        for (int i = 0; i < 8; i++) ram[14'h00C0 + 14'(i)] = 32'hEAEAEAEA;
        for (int i = 0; i < 8; i++) ram[14'h0100 + 14'(i)] = 32'hEAEAEAEA;
        ram[14'h3FFF] = 32'h3A1A0000;

        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        chk("rst_mem_req", 64'(o_mem_req), 64'd0);
        chk("rst_valid",   64'(o_valid),   64'd0);
        chk("rst_opcode",  64'(o_opcode),  64'd0);
        chk("rst_operand", 64'(o_operand), 64'd0);
        chk("rst_length",  64'(o_length),  64'd1);
        chk("rst_pc",      64'(o_pc),      64'h0000);
        @(posedge i_clk); #1;
        i_rst = 1'b0; i_ready = 1'b1;
        redir_idx = 0; new_acks = 0;
        wait_valid("reset_stream", 1);
        repeat (20) @(posedge i_clk);

        // Unaligned redirect: only the top byte of the first word is kept.
        do_redirect(16'h0203);
        wait_valid("unaligned", 2);
        chk("unaligned_first_addr", 64'(addr_log[redir_idx]), 64'h0080);
        repeat (20) @(posedge i_clk);

        // A 3-byte opcode in byte 3 of a word needs the next word before it is valid.
        do_redirect(16'h0503);
        wait_valid("span3", 2);
        repeat (20) @(posedge i_clk);

        // Redirect while a read is outstanding: that word must be dropped.
        lat_cfg = 3;
        do_redirect(16'h0100);
        cyc = 0;
        while (addr_log.size() <= redir_idx && cyc < 40) begin
            @(negedge i_clk);
            cyc++;
        end
        chk("discard_req_seen", 64'(addr_log.size() > redir_idx), 64'd1);
        do_redirect(16'h0300);
        lat_cfg = -1;
        wait_valid("discard", 1);
        chk("discard_next_addr", 64'(addr_log[redir_idx]), 64'h00C0);
        repeat (20) @(posedge i_clk);

        // Backpressure: the queue fills up and requests stop until 4 bytes are free.
        i_ready = 1'b0;
        do_redirect(16'h0400);
        repeat (30) @(posedge i_clk);
        @(negedge i_clk);
        chk("full_no_req", 64'(o_mem_req), 64'd0);
        chk("full_valid",  64'(o_valid),   64'd1);
        @(posedge i_clk); #1; i_ready = 1'b1;
        @(posedge i_clk); #1; i_ready = 1'b0;
        repeat (4) @(negedge i_clk);
        chk("free1_no_req", 64'(o_mem_req), 64'd0);
        @(posedge i_clk); #1; i_ready = 1'b1;
        repeat (3) @(posedge i_clk);
        #1; i_ready = 1'b0;
        cyc = 0;
        @(negedge i_clk);
        while (!o_mem_req && cyc < 10) begin
            @(negedge i_clk);
            cyc++;
        end
        chk("free4_req", 64'(o_mem_req), 64'd1);
        @(posedge i_clk); #1; i_ready = 1'b1;
        repeat (20) @(posedge i_clk);

        // PC wrap from FFFF to 0000.
        do_redirect(16'hFFFE);
        wait_valid("wrap", 1);
        repeat (20) @(posedge i_clk);
        chk("wrap_addr0", 64'(addr_log[redir_idx]), 64'h3FFF);
        chk("wrap_addr1", 64'(addr_log[redir_idx + 1]), 64'h0000);

        // Random phase: random ready, random redirects and random latency.
        for (int n = 0; n < 4000; n++) begin
            @(posedge i_clk); #1;
            i_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 31) == 0) begin
                i_redirect    = 1'b1;
                i_redirect_pc = 16'($urandom);
            end else begin
                i_redirect = 1'b0;
            end
        end
        @(posedge i_clk); #1;
        i_redirect = 1'b0;
        repeat (10) @(posedge i_clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
